cam_alloc: RTL and testbench
============================

// Module: cam_alloc
// PURPOSE
//  Entry allocator sitting directly upstream of the cam write ports. Keeps a valid bitmap of all
//  DEPTH cam entries and assigns free entries to up to WRITE insert requests per cycle.
//  Drives cam we_/wm/wd/waddr one cycle later and takes entry releases from downstream consumers.
//  Reports occupancy, full/empty, and illegal releases.
// PARAMETERS
//  DATA   32  data/mask width per write port (same as cam DATA)
//  DEPTH  32  number of cam entries (same as cam DEPTH)
//  WRITE   4  insert ports (same as cam WRITE)
//  FREE    2  release ports
//  ADDR   $clog2(DEPTH)  derived, not overridable
// PORTS
//  clk       in   1            clock
//  reset     in   1            synchronous, active-high reset
//  req       in   WRITE        per-port insert request, active-high, single-cycle
//  req_m     in   DATA*WRITE   per-port write mask
//  req_d     in   DATA*WRITE   per-port write data
//  gnt       out  WRITE        per-port grant, combinational, same cycle as req
//  gaddr     out  ADDR*WRITE   entry allocated to granted port (valid when gnt[i])
//  we_       out  WRITE        cam write enable, active-low, registered
//  wm        out  DATA*WRITE   cam write mask, registered
//  wd        out  DATA*WRITE   cam write data, registered
//  waddr     out  ADDR*WRITE   cam write address, registered
//  free      in   FREE         per-port release, active-high
//  free_addr in   ADDR*FREE    entry to release
//  count     out  ADDR+1       valid entries, registered
//  full      out  1            count==DEPTH, registered
//  empty     out  1            count==0, registered
//  free_err  out  1            one-cycle pulse: release of an entry that was not valid
// BEHAVIOUR
//  - Reset: valid bitmap 0, we_ all 1, wm/wd/waddr 0, count 0, full 0, empty 1, free_err 0.
//  - reset asserted mid-operation: pending writes dropped; the next cycle shows the reset values.
//  - Grant: consider requesting ports in ascending index order. The k-th requester (k=0..) is
//    granted the k-th lowest-index free entry if one exists, else gnt=0. No starvation guarantee.
//    A non-granted requester re-requests in a later cycle; there is no request holding.
//  - Allocation is registered: on the clk edge after gnt[i], valid[gaddr_i] is set, we_[i]=0,
//    and waddr/wd/wm carry the port i values for exactly one cycle. Non-granted ports: we_[i]=1,
//    and their waddr/wd/wm are don't-care (held).
//  - Release: free[j] with valid[free_addr_j]=1 clears the bit at the edge. The entry is not
//    grantable until the following cycle; there is no same-cycle bypass.
//  - free[j] with the bit already 0: ignored, and free_err pulses the next cycle.
//  - Two free ports naming the same address in one cycle: cleared once, no error.
//  - A release and a grant on different entries in the same cycle: both applied.
//  - count(next) = count + #granted - #legal distinct releases. It never wraps; the invariant
//    count==popcount(valid) holds, and ADDR+1 bits are wide enough for DEPTH.
//  - full: all req get gnt=0. empty: releases only raise free_err.
// STRUCTURE
//  - cam_pkg: ADDR computation, port-slice index functions, Enable_/Disable_ constants shared
//    with cam.
//  - Sub-module cam_free_pick (combinational): input ~valid, output the WRITE lowest free
//    indices plus their found flags. It is built as a cascaded priority encoder, each stage
//    masking the previous pick.
//  - Top level: request compaction (prefix count of req), grant mapping, bitmap and counter
//    registers, output registers.
// TESTING (DEPTH=32, WRITE=4, FREE=2)
//  1 After reset, req=4'b1111 -> gnt=4'b1111, gaddr={3,2,1,0}; next cycle we_=4'b0000,
//    waddr={3,2,1,0}, count=4.
//  2 Eight consecutive req=4'b1111 cycles -> count=32, full=1; a ninth req -> gnt=0, and the
//    next cycle shows we_=4'b1111.
//  3 Full, free={5,17} with req=4'b1111 in the same cycle -> gnt=0; next cycle req=4'b1111
//    -> gnt=4'b0011, gaddr0=5, gaddr1=17.
//  4 Entries 0..28 valid, req=4'b1010 -> gnt=4'b1010, gaddr1=29, gaddr3=30; count=31.
//  5 free_addr=9 with entry 9 invalid -> free_err=1 for one cycle, count unchanged;
//    free0=free1=7 with 7 valid -> count-1, no error.
//  6 reset asserted in the cycle after a grant -> next cycle we_=4'b1111, count=0, empty=1;
//    req=4'b0001 -> gaddr0=0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the cam and its entry allocator: address width,
// port-slice helpers and the active-low write-enable levels.
package cam_pkg;

  localparam logic Enable_  = 1'b0;
  localparam logic Disable_ = 1'b1;

  function automatic int addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Low bit of port idx inside a flattened bus of width-wide slices.
  function automatic int lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/cam_free_pick.sv
// Cascaded priority encoder: returns the WRITE lowest-index set bits of avail,
// each stage masking the entry picked by the stage before it.
module cam_free_pick
  import cam_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WRITE = 4,
  parameter int ADDR  = 5
) (
  input  logic [DEPTH-1:0]      avail,
  output logic [ADDR*WRITE-1:0] pick,
  output logic [WRITE-1:0]      found
);

  logic [DEPTH-1:0] mask;
  logic [ADDR-1:0]  idx;
  logic             hit;

  always_comb begin
    mask  = avail;
    pick  = '0;
    found = '0;
    idx   = '0;
    hit   = 1'b0;
    for (int s = 0; s < WRITE; s++) begin
      idx = '0;
      hit = 1'b0;
      // Scanning downward leaves the lowest set bit as the final winner.
      for (int e = DEPTH - 1; e >= 0; e--) begin
        if (mask[e]) begin
          idx = ADDR'(e);
          hit = 1'b1;
        end
      end
      found[s]                     = hit;
      pick[lsb(s, ADDR) +: ADDR]   = idx;
      if (hit) mask[idx] = 1'b0;
    end
  end

endmodule

// File: rtl/cam_alloc.sv
// Entry allocator in front of the cam write ports: tracks valid entries,
// grants free entries to insert requests and registers the cam write.
module cam_alloc
  import cam_pkg::*;
#(
  parameter  int DATA  = 32,
  parameter  int DEPTH = 32,
  parameter  int WRITE = 4,
  parameter  int FREE  = 2,
  localparam int ADDR  = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WRITE-1:0]      req,
  input  logic [DATA*WRITE-1:0] req_m,
  input  logic [DATA*WRITE-1:0] req_d,
  output logic [WRITE-1:0]      gnt,
  output logic [ADDR*WRITE-1:0] gaddr,
  output logic [WRITE-1:0]      we_,
  output logic [DATA*WRITE-1:0] wm,
  output logic [DATA*WRITE-1:0] wd,
  output logic [ADDR*WRITE-1:0] waddr,
  input  logic [FREE-1:0]       free,
  input  logic [ADDR*FREE-1:0]  free_addr,
  output logic [ADDR:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  free_err
);

  localparam logic [ADDR:0] FULL_CNT = (ADDR + 1)'(DEPTH);

  logic [DEPTH-1:0]      valid;
  logic [ADDR*WRITE-1:0] pick;
  logic [WRITE-1:0]      found;

  cam_free_pick #(
    .DEPTH (DEPTH),
    .WRITE (WRITE),
    .ADDR  (ADDR)
  ) u_pick (
    .avail (~valid),
    .pick  (pick),
    .found (found)
  );

  // Request compaction: the k-th requester takes the k-th free pick.
  always_comb begin : grant_map
    int rank;
    rank  = 0;
    gnt   = '0;
    gaddr = '0;
    for (int i = 0; i < WRITE; i++) begin
      if (req[i]) begin
        gnt[i]                     = found[rank];
        gaddr[lsb(i, ADDR) +: ADDR] = pick[lsb(rank, ADDR) +: ADDR];
        rank++;
      end
    end
  end

  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] clr_mask;
  logic             err_next;
  logic [ADDR:0]    n_set;
  logic [ADDR:0]    n_clr;
  logic [ADDR:0]    count_next;
  logic [ADDR-1:0]  fa;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    err_next = 1'b0;
    n_set    = '0;
    n_clr    = '0;
    fa       = '0;
    for (int i = 0; i < WRITE; i++) begin
      if (gnt[i]) set_mask[gaddr[lsb(i, ADDR) +: ADDR]] = 1'b1;
    end
    // Duplicate releases of one valid entry collapse into a single clear.
    for (int j = 0; j < FREE; j++) begin
      fa = free_addr[lsb(j, ADDR) +: ADDR];
      if (free[j]) begin
        if ((int'(fa) < DEPTH) && valid[fa]) clr_mask[fa] = 1'b1;
        else                                 err_next     = 1'b1;
      end
    end
    for (int e = 0; e < DEPTH; e++) begin
      n_set = n_set + {{ADDR{1'b0}}, set_mask[e]};
      n_clr = n_clr + {{ADDR{1'b0}}, clr_mask[e]};
    end
    count_next = count + n_set - n_clr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= '0;
      we_      <= {WRITE{Disable_}};
      wm       <= '0;
      wd       <= '0;
      waddr    <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      free_err <= 1'b0;
    end else begin
      valid    <= (valid & ~clr_mask) | set_mask;
      count    <= count_next;
      full     <= (count_next == FULL_CNT);
      empty    <= (count_next == '0);
      free_err <= err_next;
      for (int i = 0; i < WRITE; i++) begin
        we_[i] <= gnt[i] ? Enable_ : Disable_;
        if (gnt[i]) begin
          waddr[lsb(i, ADDR) +: ADDR] <= gaddr[lsb(i, ADDR) +: ADDR];
          wm[lsb(i, DATA) +: DATA]    <= req_m[lsb(i, DATA) +: DATA];
          wd[lsb(i, DATA) +: DATA]    <= req_d[lsb(i, DATA) +: DATA];
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_alloc.sv
// Directed bench for cam_alloc at DEPTH=32, WRITE=4, FREE=2, DATA=32.
module tb_cam_alloc;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] req_m;
  logic [127:0] req_d;
  logic [3:0]   gnt;
  logic [19:0]  gaddr;
  logic [3:0]   we_;
  logic [127:0] wm;
  logic [127:0] wd;
  logic [19:0]  waddr;
  logic [1:0]   free;
  logic [9:0]   free_addr;
  logic [5:0]   count;
  logic         full;
  logic         empty;
  logic         free_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cam_alloc #(.DATA(32), .DEPTH(32), .WRITE(4), .FREE(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_m     (req_m),
    .req_d     (req_d),
    .gnt       (gnt),
    .gaddr     (gaddr),
    .we_       (we_),
    .wm        (wm),
    .wd        (wd),
    .waddr     (waddr),
    .free      (free),
    .free_addr (free_addr),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .free_err  (free_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; free = '0; free_addr = '0; req_m = '0; req_d = '0;
    tick; tick;
    total++; if (we_ !== 4'b1111) begin bad++; $display("FAIL reset_we got=%b exp=1111", we_); end
    total++; if (count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags got empty=%b full=%b exp 1 0", empty, full); end
    total++; if (free_err !== 1'b0) begin bad++; $display("FAIL reset_free_err got=%b exp=0", free_err); end
    total++; if (waddr !== 20'd0 || wd !== 128'd0 || wm !== 128'd0) begin bad++; $display("FAIL reset_wport got waddr=%h exp 0", waddr); end
    reset = 1'b0;
  endtask

  task automatic test_first_alloc;
    req   = 4'b1111;
    req_d = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    req_m = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
    #1;
    total++; if (gnt !== 4'b1111) begin bad++; $display("FAIL first_gnt got=%b exp=1111", gnt); end
    total++; if (gaddr !== {5'd3, 5'd2, 5'd1, 5'd0}) begin bad++; $display("FAIL first_gaddr got=%h exp=%h", gaddr, {5'd3, 5'd2, 5'd1, 5'd0}); end
    tick;
    req = '0;
    total++; if (we_ !== 4'b0000) begin bad++; $display("FAIL first_we got=%b exp=0000", we_); end
    total++; if (waddr !== {5'd3, 5'd2, 5'd1, 5'd0}) begin bad++; $display("FAIL first_waddr got=%h", waddr); end
    total++; if (wd !== {32'hD3, 32'hD2, 32'hD1, 32'hD0} || wm !== {32'hF3, 32'hF2, 32'hF1, 32'hF0}) begin bad++; $display("FAIL first_wdata got wd=%h wm=%h", wd, wm); end
    total++; if (count !== 6'd4 || empty !== 1'b0) begin bad++; $display("FAIL first_count got=%0d empty=%b exp 4 0", count, empty); end
  endtask

  task automatic test_fill;
    for (int n = 0; n < 7; n++) begin
      req = 4'b1111;
      tick;
    end
    req = '0;
    total++; if (count !== 6'd32 || full !== 1'b1) begin bad++; $display("FAIL fill_full got count=%0d full=%b exp 32 1", count, full); end
    total++; if (waddr !== {5'd31, 5'd30, 5'd29, 5'd28}) begin bad++; $display("FAIL fill_last_waddr got=%h", waddr); end
    req = 4'b1111;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL fill_ninth_gnt got=%b exp=0000", gnt); end
    tick;
    req = '0;
    total++; if (we_ !== 4'b1111 || count !== 6'd32) begin bad++; $display("FAIL fill_ninth_we got we=%b count=%0d exp 1111 32", we_, count); end
  endtask

  task automatic test_free_no_bypass;
    free = 2'b11; free_addr = {5'd17, 5'd5}; req = 4'b1111;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL bypass_gnt got=%b exp=0000", gnt); end
    tick;
    free = '0; req = 4'b1111;
    #1;
    total++; if (gnt !== 4'b0011) begin bad++; $display("FAIL refill_gnt got=%b exp=0011", gnt); end
    total++; if (gaddr[4:0] !== 5'd5 || gaddr[9:5] !== 5'd17) begin bad++; $display("FAIL refill_gaddr got g0=%0d g1=%0d exp 5 17", gaddr[4:0], gaddr[9:5]); end
    tick;
    req = '0;
    total++; if (we_ !== 4'b1100 || count !== 6'd32) begin bad++; $display("FAIL refill_we got we=%b count=%0d exp 1100 32", we_, count); end
    total++; if (waddr[4:0] !== 5'd5 || waddr[9:5] !== 5'd17) begin bad++; $display("FAIL refill_waddr got %0d %0d exp 5 17", waddr[4:0], waddr[9:5]); end
  endtask

  task automatic test_sparse_req;
    free = 2'b11; free_addr = {5'd30, 5'd29}; tick;
    free = 2'b01; free_addr = {5'd0, 5'd31};  tick;
    free = '0;
    total++; if (count !== 6'd29 || full !== 1'b0) begin bad++; $display("FAIL sparse_pre got count=%0d full=%b exp 29 0", count, full); end
    req = 4'b1010;
    #1;
    total++; if (gnt !== 4'b1010) begin bad++; $display("FAIL sparse_gnt got=%b exp=1010", gnt); end
    total++; if (gaddr[9:5] !== 5'd29 || gaddr[19:15] !== 5'd30) begin bad++; $display("FAIL sparse_gaddr got g1=%0d g3=%0d exp 29 30", gaddr[9:5], gaddr[19:15]); end
    tick;
    req = '0;
    total++; if (count !== 6'd31 || we_ !== 4'b0101) begin bad++; $display("FAIL sparse_count got count=%0d we=%b exp 31 0101", count, we_); end
  endtask

  task automatic test_free_err;
    free = 2'b01; free_addr = {5'd0, 5'd9}; tick;
    total++; if (count !== 6'd30 || free_err !== 1'b0) begin bad++; $display("FAIL legal_free got count=%0d err=%b exp 30 0", count, free_err); end
    tick;
    free = '0;
    total++; if (free_err !== 1'b1 || count !== 6'd30) begin bad++; $display("FAIL bad_free got err=%b count=%0d exp 1 30", free_err, count); end
    tick;
    total++; if (free_err !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b exp=0", free_err); end
    free = 2'b11; free_addr = {5'd7, 5'd7}; tick;
    free = '0;
    total++; if (count !== 6'd29 || free_err !== 1'b0) begin bad++; $display("FAIL dup_free got count=%0d err=%b exp 29 0", count, free_err); end
    free = 2'b10; free_addr = {5'd7, 5'd0}; tick;
    free = '0;
    total++; if (free_err !== 1'b1 || count !== 6'd29) begin bad++; $display("FAIL port1_err got err=%b count=%0d exp 1 29", free_err, count); end
  endtask

  task automatic test_reset_mid;
    req = 4'b0001;
    #1;
    total++; if (gnt !== 4'b0001 || gaddr[4:0] !== 5'd7) begin bad++; $display("FAIL mid_pre_gnt got gnt=%b g0=%0d exp 0001 7", gnt, gaddr[4:0]); end
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0; req = '0;
    total++; if (we_ !== 4'b1111 || count !== 6'd0 || empty !== 1'b1) begin bad++; $display("FAIL mid_reset got we=%b count=%0d empty=%b exp 1111 0 1", we_, count, empty); end
    req = 4'b0001;
    #1;
    total++; if (gnt !== 4'b0001 || gaddr[4:0] !== 5'd0) begin bad++; $display("FAIL mid_regrant got gnt=%b g0=%0d exp 0001 0", gnt, gaddr[4:0]); end
    tick;
    req = '0;
    total++; if (count !== 6'd1 || we_ !== 4'b1110) begin bad++; $display("FAIL mid_count got count=%0d we=%b exp 1 1110", count, we_); end
  endtask

  task automatic test_back_to_back;
    free = 2'b01; free_addr = {5'd0, 5'd0}; req = 4'b0011;
    #1;
    total++; if (gnt !== 4'b0011 || gaddr[9:0] !== {5'd2, 5'd1}) begin bad++; $display("FAIL b2b_gnt got gnt=%b ga=%h exp 0011 %h", gnt, gaddr[9:0], {5'd2, 5'd1}); end
    tick;
    free = '0; req = 4'b0001;
    total++; if (count !== 6'd2 || we_ !== 4'b1100 || free_err !== 1'b0) begin bad++; $display("FAIL b2b_count got count=%0d we=%b err=%b exp 2 1100 0", count, we_, free_err); end
    #1;
    total++; if (gnt !== 4'b0001 || gaddr[4:0] !== 5'd0) begin bad++; $display("FAIL b2b_reuse got gnt=%b g0=%0d exp 0001 0", gnt, gaddr[4:0]); end
    tick;
    req = '0;
    total++; if (count !== 6'd3 || waddr[4:0] !== 5'd0 || we_ !== 4'b1110) begin bad++; $display("FAIL b2b_final got count=%0d wa0=%0d we=%b exp 3 0 1110", count, waddr[4:0], we_); end
  endtask

  initial begin
    test_reset;
    test_first_alloc;
    test_fill;
    test_free_no_bypass;
    test_sparse_req;
    test_free_err;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
